md_seq: RTL and testbench

MD_SEQ -- requirements
Module: md_seq

---
 rtl/md_seq.sv | 176 +++++++++++++++++
 tb/tb_md_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/md_seq.sv
// md_seq: RV32M multiply/divide sequencer (one-cycle multiply, 32-step restoring divide).
// Optional macro MD_EARLY_OUT_EN finishes a divide at once when |rs1| < |rs2|.
module md_seq #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DWIDTH-1:0] rs1_val,
    input  logic [DWIDTH-1:0] rs2_val,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] result,
    output logic [4:0]        out_rd,
    output logic              busy
);
    // state | meaning
    // IDLE  | waiting for a request
    // MUL   | forming the 64-bit product
    // DIV   | cnt_q != 0: one restoring step per cycle; cnt_q == 0: apply signs
    // DONE  | result held until out_ready
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    state_t      state_q, state_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] result_q, result_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;

    logic        is_md;
    logic        div_signed;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_a, mul_b;
    logic [65:0] prod;
    logic [32:0] shifted, diff;
    logic [31:0] quo_fin, rem_fin;
    logic        unused_bits;

    assign is_md      = (instr[6:0] == 7'b0110011) && (instr[31:25] == 7'b0000001);
    assign div_signed = ~instr[12];
    assign mag_a      = (div_signed && rs1_val[31]) ? -rs1_val : rs1_val;
    assign mag_b      = (div_signed && rs2_val[31]) ? -rs2_val : rs2_val;

    // rs1 is signed for all but MULHU, rs2 only for MUL/MULH
    assign mul_a = {(f3_q != 3'b011) && a_q[31], a_q};
    assign mul_b = {!f3_q[1] && b_q[31], b_q};
    assign prod  = {{33{mul_a[32]}}, mul_a} * {{33{mul_b[32]}}, mul_b};

    // a_q doubles as the dividend/quotient shift register; diff[32] is the borrow
    assign shifted = {rem_q, a_q[31]};
    assign diff    = shifted - {1'b0, b_q};
    assign quo_fin = qneg_q ? -a_q : a_q;
    assign rem_fin = rneg_q ? -rem_q : rem_q;

    assign unused_bits = ^{instr[24:15], prod[65:64]};

    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && is_md) begin
                    f3_d = instr[14:12];
                    rd_d = instr[11:7];
                    if (!instr[14]) begin
                        a_d     = rs1_val;
                        b_d     = rs2_val;
                        state_d = ST_MUL;
                    end else if (rs2_val == '0) begin
                        result_d = instr[13] ? rs1_val : '1;
                        state_d  = ST_DONE;
                    end else if (div_signed && rs1_val == INT_MIN && rs2_val == '1) begin
                        result_d = instr[13] ? '0 : INT_MIN;
                        state_d  = ST_DONE;
                    end else begin
                        qneg_d  = div_signed && (rs1_val[31] ^ rs2_val[31]);
                        rneg_d  = div_signed && rs1_val[31];
                        b_d     = mag_b;
                        state_d = ST_DIV;
`ifdef MD_EARLY_OUT_EN
                        if (mag_a < mag_b) begin
                            a_d   = '0;
                            rem_d = mag_a;
                            cnt_d = '0;
                        end else begin
                            a_d   = mag_a;
                            rem_d = '0;
                            cnt_d = 6'd32;
                        end
`else
                        a_d   = mag_a;
                        rem_d = '0;
                        cnt_d = 6'd32;
`endif
                    end
                end
            end
            ST_MUL: begin
                result_d = (f3_q == 3'b000) ? prod[31:0] : prod[63:32];
                state_d  = ST_DONE;
            end
            ST_DIV: begin
                if (cnt_q != '0) begin
                    rem_d = diff[32] ? shifted[31:0] : diff[31:0];
                    a_d   = {a_q[30:0], ~diff[32]};
                    cnt_d = cnt_q - 6'd1;
                end else begin
                    result_d = f3_q[1] ? rem_fin : quo_fin;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    result_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d  = ST_IDLE;
            result_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            f3_q     <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !reset;
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = out_valid ? result_q : '0;
    assign out_rd    = out_valid ? rd_q : '0;

endmodule

// File: tb/tb_md_seq.sv
// Self-checking bench for md_seq: vector table through a scoreboard plus flush/reset/hold sequences.
module tb_md_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_val, rs2_val;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  out_rd;
    logic        busy;

    md_seq #(.DWIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_rd(out_rd), .busy(busy)
    );

    always #5 clk = ~clk;

`ifdef MD_EARLY_OUT_EN
    localparam int EO_LAT = 2;
`else
    localparam int EO_LAT = 34;
`endif

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        vt[18];
    logic [36:0] sb_q[$];
    int          n_pass = 0;
    int          n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp);
        @(negedge clk);
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        instr    = mk(f3, rd);
        rs1_val  = a;
        rs2_val  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb_q.push_back({rd, exp});
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic collect(input string name, input int lat, input int hold);
        int          cyc;
        logic [36:0] e;
        wait_valid(cyc);
        if (!out_valid) begin
            chk({name, "_timeout"}, 64'd0, 64'd1);
            sb_q.delete();
            return;
        end
        if (lat != 0) chk({name, "_latency"}, 64'(cyc + 1), 64'(lat));
        e = sb_q.pop_front();
        chk({name, "_result"}, 64'(result), 64'(e[31:0]));
        chk({name, "_rd"}, 64'(out_rd), 64'(e[36:32]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({name, "_hold"}, {25'd0, out_valid, busy, in_ready, out_rd, result},
                {25'd0, 1'b1, 1'b1, 1'b0, e[36:32], e[31:0]});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_release"}, {out_valid, busy, out_rd, result}, 64'd0);
    endtask

    initial begin
        int cyc;
        int seen;

        vt[0]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'h00000001, 2};
        vt[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'h00000000, 2};
        vt[2]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFF, 2};
        vt[3]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE, 2};
        vt[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 34};
        vt[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 34};
        vt[6]  = '{3'b101, 32'd100,      32'd0,        5'd11, 32'hFFFFFFFF, 0};
        vt[7]  = '{3'b111, 32'd100,      32'd0,        5'd12, 32'd100,      0};
        vt[8]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 0};
        vt[9]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h00000000, 0};
        vt[10] = '{3'b101, 32'd3,        32'd5,        5'd15, 32'd0,        EO_LAT};
        vt[11] = '{3'b111, 32'd3,        32'd5,        5'd16, 32'd3,        EO_LAT};
        vt[12] = '{3'b000, 32'd3,        32'd4,        5'd17, 32'd12,       2};
        vt[13] = '{3'b101, 32'd100,      32'd7,        5'd18, 32'd14,       34};
        vt[14] = '{3'b111, 32'd100,      32'd7,        5'd19, 32'd2,        34};
        vt[15] = '{3'b001, 32'h80000000, 32'h80000000, 5'd20, 32'h40000000, 2};
        vt[16] = '{3'b100, 32'd7,        32'hFFFFFFFE, 5'd21, 32'hFFFFFFFD, 34};
        vt[17] = '{3'b110, 32'd7,        32'hFFFFFFFE, 5'd22, 32'd1,        34};

        reset = 1'b1; in_valid = 1'b0; instr = '0; rs1_val = '0; rs2_val = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {out_valid, busy, out_rd, result}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_after_reset", {in_ready, busy}, 64'b10);

        for (int i = 0; i < 18; i++) begin
            issue(vt[i].f3, vt[i].a, vt[i].b, vt[i].rd, vt[i].exp);
            collect($sformatf("vec%0d", i), vt[i].lat, 0);
        end

        // DONE held with out_ready low for 5 cycles
        issue(3'b000, 32'd6, 32'd7, 5'd9, 32'd42);
        collect("hold", 2, 5);

        // non-RV32M request is dropped
        @(negedge clk);
        in_valid = 1'b1; instr = 32'h00208033; rs1_val = 32'd1; rs2_val = 32'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("drop_busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (5) begin @(posedge clk); #1; seen += int'(out_valid); end
        chk("drop_no_valid", 64'(seen), 64'd0);

        // flush in the same cycle as an accept
        @(negedge clk);
        in_valid = 1'b1; instr = mk(3'b000, 5'd3); rs1_val = 32'd2; rs2_val = 32'd2; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_accept_busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (4) begin @(posedge clk); #1; seen += int'(out_valid); end
        chk("flush_accept_no_valid", 64'(seen), 64'd0);

        // flush at iteration 10 of a DIV, then a MUL
        issue(3'b100, 32'd1000, 32'd3, 5'd4, 32'd333);
        repeat (9) @(posedge clk);
        #1;
        chk("div_busy_before_flush", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        sb_q.delete();
        chk("flush_div_idle", {busy, out_valid, in_ready}, 64'b001);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; seen += int'(out_valid); end
        chk("flush_div_no_valid", 64'(seen), 64'd0);
        issue(3'b000, 32'd3, 32'd4, 5'd1, 32'd12);
        collect("mul_after_flush", 2, 0);

        // reset mid-DIV
        issue(3'b101, 32'd1000, 32'd3, 5'd2, 32'd333);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset_mid_div", {in_ready, out_valid, busy, out_rd, result}, 64'd0);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_mid_reset", {in_ready, busy}, 64'b10);

        // reset while a result is held
        issue(3'b000, 32'd6, 32'd7, 5'd9, 32'd42);
        wait_valid(cyc);
        chk("pre_reset_held", {out_valid, out_rd, result}, {1'b1, 5'd9, 32'd42});
        reset = 1'b1;
        #1;
        chk("reset_in_done", {out_valid, busy, out_rd, result}, 64'd0);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // a full divide after reset recovery
        issue(3'b100, 32'hFFFFFFF9, 32'd2, 5'd30, 32'hFFFFFFFD);
        collect("div_after_reset", 34, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
